// File: rtl/kyber_decrypt_seq.sv
// Sequential Kyber-style decryption core.
// Computes msg[i] = decode(v[i] - sum_k (sk[k] * u[k])[i]) over Z_Q[x]/(x^N + 1).
// The inner product is formed one coefficient product per clock, so a full
// decryption takes K*N*N MAC cycles. The result is held until the consumer
// accepts it.
module kyber_decrypt_seq #(
   parameter int N      = 4,
   parameter int K      = 2,
   parameter int Q      = 17,
   parameter int W      = 32,
   parameter int DEC_LO = 5,
   parameter int DEC_HI = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [K*N*W-1:0]   sk,
   input  logic [K*N*W-1:0]   u,
   input  logic [N*W-1:0]     v,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N-1:0]       msg,
   output logic [N-1:0]       msg_rev,
   output logic               busy
);

   // Accumulator carries the full-precision sum of K*N products plus headroom
   // for the subtraction from v, so nothing is truncated before reduction.
   localparam int ACC_W = 2*W + $clog2(K*N) + 2;
   localparam int IW    = (N > 1) ? $clog2(N) : 1;
   localparam int KW    = (K > 1) ? $clog2(K) : 1;

   localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N-1);
   localparam logic [KW-1:0] K_ZERO   = {KW{1'b0}};
   localparam logic [KW-1:0] K_ONE    = KW'(1);
   localparam logic [KW-1:0] K_LAST   = KW'(K-1);

   localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
   localparam logic signed [ACC_W-1:0] Q_S      = ACC_W'(Q);
   localparam logic signed [ACC_W-1:0] DEC_LO_S = ACC_W'(DEC_LO);
   localparam logic signed [ACC_W-1:0] DEC_HI_S = ACC_W'(DEC_HI);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]                state_r;
   logic [K*N*W-1:0]          sk_r;
   logic [K*N*W-1:0]          u_r;
   logic [N*W-1:0]            v_r;
   logic [IW-1:0]             i_r;
   logic [KW-1:0]             k_r;
   logic [IW-1:0]             j_r;
   logic signed [ACC_W-1:0]   acc_r;
   logic [N-1:0]              msg_r;
   logic                      in_ready_r;
   logic                      out_valid_r;
   logic                      busy_r;

   logic                      accept_s;
   logic                      wrap_s;
   logic                      row_end_s;
   logic                      dec_bit_s;
   int                        sk_idx_s;
   logic signed [W-1:0]       u_coef_s;
   logic signed [W-1:0]       sk_coef_s;
   logic signed [W-1:0]       v_coef_s;
   logic signed [2*W-1:0]     u_ext_s;
   logic signed [2*W-1:0]     sk_ext_s;
   logic signed [2*W-1:0]     prod_s;
   logic signed [ACC_W-1:0]   prod_ext_s;
   logic signed [ACC_W-1:0]   term_s;
   logic signed [ACC_W-1:0]   sum_s;
   logic signed [ACC_W-1:0]   v_ext_s;
   logic signed [ACC_W-1:0]   t_s;
   logic signed [ACC_W-1:0]   rem_s;
   logic signed [ACC_W-1:0]   r_s;

   assign accept_s = in_ready_r && in_valid;

   // Negacyclic product term, row residue and decoded bit for the current (i,k,j).
   always_comb begin
      wrap_s = (j_r > i_r);
      if (wrap_s) begin
         sk_idx_s = int'(i_r) + N - int'(j_r);
      end else begin
         sk_idx_s = int'(i_r) - int'(j_r);
      end
      u_coef_s   = u_r[(int'(k_r)*N + int'(j_r))*W +: W];
      sk_coef_s  = sk_r[(int'(k_r)*N + sk_idx_s)*W +: W];
      v_coef_s   = v_r[int'(i_r)*W +: W];
      u_ext_s    = {{W{u_coef_s[W-1]}}, u_coef_s};
      sk_ext_s   = {{W{sk_coef_s[W-1]}}, sk_coef_s};
      prod_s     = u_ext_s * sk_ext_s;
      prod_ext_s = {{(ACC_W-2*W){prod_s[2*W-1]}}, prod_s};
      // x^N = -1: a wrapped index contributes with negative sign.
      if (wrap_s) begin
         term_s = -prod_ext_s;
      end else begin
         term_s = prod_ext_s;
      end
      sum_s   = acc_r + term_s;
      v_ext_s = {{(ACC_W-W){v_coef_s[W-1]}}, v_coef_s};
      t_s     = v_ext_s - sum_s;
      // Signed % keeps the dividend's sign; fold negatives into [0, Q-1].
      rem_s   = t_s % Q_S;
      if (rem_s[ACC_W-1]) begin
         r_s = rem_s + Q_S;
      end else begin
         r_s = rem_s;
      end
      dec_bit_s = (r_s >= DEC_LO_S) && (r_s <= DEC_HI_S);
      row_end_s = (k_r == K_LAST) && (j_r == IDX_LAST);
   end

   // Operand capture: only an accepted handshake in IDLE updates the copies.
   always_ff @(posedge clk) begin
      if (!rst && accept_s) begin
         sk_r <= sk;
         u_r  <= u;
         v_r  <= v;
      end else begin
         sk_r <= sk_r;
         u_r  <= u_r;
         v_r  <= v_r;
      end
   end

   // Control FSM, loop counters, accumulator and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         msg_r       <= {N{1'b0}};
         i_r         <= IDX_ZERO;
         k_r         <= K_ZERO;
         j_r         <= IDX_ZERO;
         acc_r       <= ACC_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  state_r    <= ST_MAC;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  i_r        <= IDX_ZERO;
                  k_r        <= K_ZERO;
                  j_r        <= IDX_ZERO;
                  acc_r      <= ACC_ZERO;
               end
            end
            ST_MAC: begin
               if (row_end_s) begin
                  msg_r[i_r] <= dec_bit_s;
                  acc_r      <= ACC_ZERO;
                  k_r        <= K_ZERO;
                  j_r        <= IDX_ZERO;
                  if (i_r == IDX_LAST) begin
                     i_r         <= IDX_ZERO;
                     state_r     <= ST_DONE;
                     busy_r      <= 1'b0;
                     out_valid_r <= 1'b1;
                  end else begin
                     i_r <= i_r + IDX_ONE;
                  end
               end else begin
                  acc_r <= sum_s;
                  if (j_r == IDX_LAST) begin
                     j_r <= IDX_ZERO;
                     k_r <= k_r + K_ONE;
                  end else begin
                     j_r <= j_r + IDX_ONE;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_r     <= ST_IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // Bit-reversed view of the held result.
   always_comb begin
      msg_rev = {N{1'b0}};
      for (int b = 0; b < N; b++) begin
         msg_rev[N-1-b] = msg_r[b];
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign msg       = msg_r;

endmodule

// File: tb/tb_kyber_decrypt_seq.sv
// Self-checking bench for kyber_decrypt_seq: directed vectors, latency,
// backpressure, reset abort and back-to-back traffic against a polynomial model.
module tb_kyber_decrypt_seq;

   localparam int N      = 4;
   localparam int K      = 2;
   localparam int Q      = 17;
   localparam int W      = 32;
   localparam int DEC_LO = 5;
   localparam int DEC_HI = 14;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [K*N*W-1:0]   sk;
   logic [K*N*W-1:0]   u;
   logic [N*W-1:0]     v;
   logic               out_valid;
   logic               out_ready;
   logic [N-1:0]       msg;
   logic [N-1:0]       msg_rev;
   logic               busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [N-1:0] exp_q[$];
   int           accept_cycles[$];
   int           cycle_cnt = 0;
   logic [N-1:0] sb_exp;

   always #5 clk = ~clk;

   kyber_decrypt_seq #(
      .N(N), .K(K), .Q(Q), .W(W), .DEC_LO(DEC_LO), .DEC_HI(DEC_HI)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sk(sk), .u(u), .v(v), .out_valid(out_valid), .out_ready(out_ready),
      .msg(msg), .msg_rev(msg_rev), .busy(busy)
   );

   task automatic check_value(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] rev_bits(input logic [N-1:0] m);
      logic [N-1:0] r;
      for (int b = 0; b < N; b++) r[N-1-b] = m[b];
      return r;
   endfunction

   function automatic logic [N*W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
      logic [N*W-1:0] p;
      p[0*W +: W] = c0;
      p[1*W +: W] = c1;
      p[2*W +: W] = c2;
      p[3*W +: W] = c3;
      return p;
   endfunction

   // Reference: full polynomial product reduced by x^N = -1, then decode.
   function automatic logic [N-1:0] model_msg(input logic [K*N*W-1:0] skp,
                                              input logic [K*N*W-1:0] up,
                                              input logic [N*W-1:0] vp);
      longint c[N];
      longint a, b, t, r;
      logic [N-1:0] m;
      for (int n = 0; n < N; n++) c[n] = 0;
      for (int kk = 0; kk < K; kk++) begin
         for (int ai = 0; ai < N; ai++) begin
            for (int bi = 0; bi < N; bi++) begin
               a = longint'($signed(skp[(kk*N+ai)*W +: W]));
               b = longint'($signed(up[(kk*N+bi)*W +: W]));
               if (ai + bi < N) c[ai+bi] += a * b;
               else             c[ai+bi-N] -= a * b;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         t = longint'($signed(vp[i*W +: W])) - c[i];
         r = t % Q;
         if (r < 0) r += Q;
         m[i] = (r >= DEC_LO) && (r <= DEC_HI);
      end
      return m;
   endfunction

   task automatic rand_ops();
      for (int n = 0; n < K*N; n++) begin
         sk[n*W +: W] = int'($urandom_range(0, 2000)) - 1000;
         u[n*W +: W]  = int'($urandom_range(0, 2000)) - 1000;
      end
      for (int n = 0; n < N; n++) v[n*W +: W] = int'($urandom_range(0, 2000)) - 1000;
   endtask

   // Scoreboard monitor: samples mid-low-phase, after the driver has settled.
   always @(negedge clk) begin
      #2;
      cycle_cnt++;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) begin
            exp_q.push_back(model_msg(sk, u, v));
            accept_cycles.push_back(cycle_cnt);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_value("sb_underflow", 1, 0);
            end else begin
               sb_exp = exp_q.pop_front();
               check_value("sb_msg", msg, sb_exp);
               check_value("sb_msg_rev", msg_rev, rev_bits(sb_exp));
            end
         end
      end
   end

   task automatic run_txn(input logic [K*N*W-1:0] s_in, input logic [K*N*W-1:0] u_in,
                          input logic [N*W-1:0] v_in, input logic [N-1:0] exp_msg,
                          input string tag);
      int cnt;
      sk = s_in; u = u_in; v = v_in; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_value({tag, "_busy"}, busy, 1);
      check_value({tag, "_in_ready_low"}, in_ready, 0);
      cnt = 0;
      while (!out_valid && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check_value({tag, "_latency"}, cnt, 32);
      check_value({tag, "_msg"}, msg, exp_msg);
      check_value({tag, "_msg_rev"}, msg_rev, rev_bits(exp_msg));
      check_value({tag, "_busy_done"}, busy, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_value({tag, "_out_valid_clr"}, out_valid, 0);
      check_value({tag, "_in_ready_back"}, in_ready, 1);
   endtask

   initial begin
      logic [K*N*W-1:0] zero_kn;
      logic [N-1:0]     exp_bp;
      logic [N-1:0]     held;
      int               cnt;
      int               n_acc;
      int               seen;
      int               start_n;

      zero_kn   = {(K*N*W){1'b0}};
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sk = zero_kn; u = zero_kn; v = {(N*W){1'b0}};

      // Reset state
      repeat (2) @(negedge clk);
      check_value("rst_in_ready", in_ready, 1);
      check_value("rst_out_valid", out_valid, 0);
      check_value("rst_busy", busy, 0);
      check_value("rst_msg", msg, 0);
      check_value("rst_msg_rev", msg_rev, 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors
      run_txn(zero_kn, zero_kn, pack4(8, 0, 0, 16), 4'b0001, "v034");
      run_txn(zero_kn, zero_kn, pack4(-3, -12, -13, -20), 4'b1011, "v035");
      run_txn({pack4(0, 0, 0, 0), pack4(0, 1, 0, 0)}, {pack4(0, 0, 0, 0), pack4(0, 0, 0, 1)},
              pack4(4, 0, 0, 0), 4'b0001, "v036");

      // Reset during MAC aborts the transaction
      sk = zero_kn; u = zero_kn; v = pack4(-3, -12, -13, -20); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_value("abort_out_valid", out_valid, 0);
      check_value("abort_busy", busy, 0);
      check_value("abort_in_ready", in_ready, 1);
      check_value("abort_msg", msg, 0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_value("abort_no_output", seen, 0);
      run_txn(zero_kn, zero_kn, pack4(8, 0, 0, 16), 4'b0001, "after_abort");

      // Backpressure: result held while out_ready is low, no second accept
      rand_ops();
      exp_bp = model_msg(sk, u, v);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check_value("bp_latency", cnt, 32);
      check_value("bp_msg", msg, exp_bp);
      held  = msg;
      n_acc = accept_cycles.size();
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         rand_ops();
         @(negedge clk);
         check_value("bp_out_valid", out_valid, 1);
         check_value("bp_msg_hold", msg, held);
         check_value("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check_value("bp_no_accept", accept_cycles.size(), n_acc);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_value("bp_released", out_valid, 0);

      // Back-to-back traffic with operands changing every cycle
      start_n   = accept_cycles.size();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      cnt = 0;
      while (accept_cycles.size() < start_n + 5 && cnt < 400) begin
         rand_ops();
         @(negedge clk);
         cnt++;
      end
      in_valid = 1'b0;
      check_value("b2b_accepts", accept_cycles.size() - start_n, 5);
      for (int a = start_n + 1; a < accept_cycles.size(); a++) begin
         check_value("b2b_spacing", accept_cycles[a] - accept_cycles[a-1], 34);
      end
      cnt = 0;
      while (exp_q.size() != 0 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      repeat (2) @(negedge clk);
      out_ready = 1'b0;
      check_value("sb_drained", exp_q.size(), 0);
      check_value("final_idle", in_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/kyber_decrypt_seq.md
KYBER_DECRYPT_SEQ -- requirements
Module: kyber_decrypt_seq

Interface
REQ-001 Parameter N, default 4: polynomial degree, i.e. coefficients per polynomial and message bits.
REQ-002 Parameter K, default 2: module rank, i.e. number of polynomials in sk and u.
REQ-003 Parameter Q, default 17: modulus.
REQ-004 Parameter W, default 32: signed coefficient width.
REQ-005 Parameter DEC_LO, default 5: lowest reduced value that decodes to 1.
REQ-006 Parameter DEC_HI, default 14: highest reduced value that decodes to 1.
REQ-007 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1: reset, synchronous and active-high.
REQ-009 Port in_valid, input, 1: operands valid.
REQ-010 Port in_ready, output, 1: block can accept operands.
REQ-011 Port sk, input, K*N*W: secret key; coefficient j of polynomial k is at bits [(k*N+j)*W +: W], signed.
REQ-012 Port u, input, K*N*W: ciphertext vector part; same packing as sk.
REQ-013 Port v, input, N*W: ciphertext scalar polynomial; coefficient i is at bits [i*W +: W], signed.
REQ-014 Port out_valid, output, 1: result valid.
REQ-015 Port out_ready, input, 1: consumer accepts the result.
REQ-016 Port msg, output, N: msg[i] is the decoded bit of coefficient i.
REQ-017 Port msg_rev, output, N: bit-reversed msg, msg_rev[N-1-i] = msg[i]; for N=4 this is the legacy decimal_value.
REQ-018 Port busy, output, 1: high in MAC state.

Function
REQ-019 The block SHALL use FSM states IDLE, MAC, DONE.
REQ-020 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-021 On in_valid&&in_ready, sk/u/v SHALL be registered, all accumulators and counters cleared, and the FSM SHALL move to MAC.
REQ-022 In MAC, one product SHALL be computed per cycle, with nested counters i (outer, 0..N-1), k (0..K-1) and j (inner, 0..N-1).
REQ-023 Each MAC cycle SHALL add s*u[k][j]*sk[k][(i-j) mod N] to acc, where s=+1 if j<=i and s=-1 if j>i (negacyclic, x^N = -1).
REQ-024 acc SHALL be signed and at least 2W+clog2(K*N)+1 bits wide; no truncation before reduction.
REQ-025 In the cycle where k=K-1 and j=N-1, the block SHALL form t = v[i] - (acc + last product) and r = ((t mod Q)+Q) mod Q, with r in [0,Q-1].
REQ-026 In that same cycle, msg[i] SHALL be registered as 1 iff DEC_LO <= r <= DEC_HI, acc SHALL be cleared, and i SHALL advance.
REQ-027 After the cycle with i=N-1, k=K-1, j=N-1, the FSM SHALL enter DONE; MAC lasts exactly K*N*N cycles (32 at defaults).
REQ-028 In DONE, out_valid SHALL be 1 and msg/msg_rev SHALL be held stable until out_ready.
REQ-029 On out_valid&&out_ready the FSM SHALL return to IDLE; acceptance of the next operands SHALL be no earlier than the following cycle.
REQ-030 in_valid asserted outside IDLE SHALL be ignored, and operand changes outside IDLE SHALL have no effect.
REQ-031 msg SHALL keep the last result until a new transaction overwrites its bits.

Reset
REQ-032 While rst=1 at a clock edge, the FSM SHALL go to IDLE and msg, out_valid, busy, counters and acc SHALL all be cleared to 0; in_ready SHALL be 1 after the edge.
REQ-033 rst asserted in MAC or DONE SHALL abort the transaction with no output produced; rst has priority over all handshakes.

Verification
REQ-034 Defaults, sk=0, u=0, v={8,0,0,16} -> after 32 MAC cycles out_valid=1, msg=4'b0001, msg_rev=4'b1000.
REQ-035 sk=0, v={-3,-12,-13,-20} (r={14,5,4,14}) -> msg=4'b1011.
REQ-036 Negacyclic check: sk[0]={0,1,0,0}, u[0]={0,0,0,1}, sk[1]=u[1]=0, v={4,0,0,0} (acc0=-1, r0=5) -> msg=4'b0001.
REQ-037 Latency and backpressure: out_valid rises exactly 32 cycles after the accept edge; hold out_ready=0 for 10 cycles while pulsing in_valid -> out_valid and msg stay stable, in_ready=0, and no second accept occurs.
REQ-038 rst pulsed at MAC cycle 10 -> next cycle out_valid=0, busy=0, in_ready=1, msg=0; a following REQ-034 transaction gives msg=4'b0001.
REQ-039 Back-to-back: out_ready tied to 1 and in_valid held high -> accepts are spaced exactly 34 cycles apart, and every result matches a software negacyclic model.
